// File: rtl/fft_input_packer.sv
// fft_input_packer: serial-to-parallel front end of the FFT pipeline.
// Collects LANES consecutive complex samples into one parallel beat, pulses
// dout_valid for one cycle per beat and marks the first/last beat of each
// FRAME_LEN-sample frame.
// Optional feature macro: FFT_PACKER_FRAME_SYNC_EN adds in_sof (frame
// realignment input) and sync_err (misalignment pulse).
module fft_input_packer #(
    parameter int IN_WIDTH  = 11,
    parameter int LANES     = 16,
    parameter int FRAME_LEN = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [IN_WIDTH-1:0] in_i,
    input  logic signed [IN_WIDTH-1:0] in_q,
`ifdef FFT_PACKER_FRAME_SYNC_EN
    input  logic                       in_sof,
    output logic                       sync_err,
`endif
    output logic                       dout_valid,
    output logic signed [IN_WIDTH-1:0] dout_i [0:LANES-1],
    output logic signed [IN_WIDTH-1:0] dout_q [0:LANES-1],
    output logic                       dout_sof,
    output logic                       dout_eof,
    output logic [$clog2(FRAME_LEN/LANES)-1:0] beat_idx
);

    localparam int BEATS  = FRAME_LEN / LANES;
    localparam int LANE_W = $clog2(LANES);
    localparam int BEAT_W = $clog2(BEATS);

    // Position counters
    logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    // Effective write position after any frame realignment
    logic [LANE_W-1:0] lane_sel_s;
    logic [BEAT_W-1:0] beat_sel_s;
    logic              sync_err_q, sync_err_d;

    // Staging for lanes 0..LANES-2; the last lane bypasses staging
    logic signed [IN_WIDTH-1:0] stage_i_q [0:LANES-2];
    logic signed [IN_WIDTH-1:0] stage_q_q [0:LANES-2];
    logic signed [IN_WIDTH-1:0] stage_i_d [0:LANES-2];
    logic signed [IN_WIDTH-1:0] stage_q_d [0:LANES-2];

    // Registered outputs
    logic signed [IN_WIDTH-1:0] dout_i_q [0:LANES-1];
    logic signed [IN_WIDTH-1:0] dout_q_q [0:LANES-1];
    logic signed [IN_WIDTH-1:0] dout_i_d [0:LANES-1];
    logic signed [IN_WIDTH-1:0] dout_q_d [0:LANES-1];
    logic              dout_valid_q, dout_valid_d;
    logic              dout_sof_q, dout_sof_d;
    logic              dout_eof_q, dout_eof_d;
    logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;

    // Resolve where the incoming sample lands; an in_sof restarts at lane 0, beat 0
    always_comb begin
        lane_sel_s = lane_cnt_q;
        beat_sel_s = beat_cnt_q;
        sync_err_d = 1'b0;
`ifdef FFT_PACKER_FRAME_SYNC_EN
        if (in_valid && in_sof) begin
            lane_sel_s = LANE_W'(0);
            beat_sel_s = BEAT_W'(0);
            sync_err_d = (lane_cnt_q != LANE_W'(0)) || (beat_cnt_q != BEAT_W'(0));
        end else begin
            lane_sel_s = lane_cnt_q;
            beat_sel_s = beat_cnt_q;
            sync_err_d = 1'b0;
        end
`endif
    end

    // Next-state: stage samples, emit a beat when the last lane arrives
    always_comb begin
        lane_cnt_d   = lane_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        dout_valid_d = 1'b0;
        dout_sof_d   = 1'b0;
        dout_eof_d   = 1'b0;
        beat_idx_d   = beat_idx_q;
        for (int k = 0; k < LANES - 1; k++) begin
            stage_i_d[k] = stage_i_q[k];
            stage_q_d[k] = stage_q_q[k];
        end
        for (int k = 0; k < LANES; k++) begin
            dout_i_d[k] = dout_i_q[k];
            dout_q_d[k] = dout_q_q[k];
        end

        if (in_valid) begin
            if (lane_sel_s == LANE_W'(LANES - 1)) begin
                for (int k = 0; k < LANES - 1; k++) begin
                    dout_i_d[k] = stage_i_q[k];
                    dout_q_d[k] = stage_q_q[k];
                end
                dout_i_d[LANES-1] = in_i;
                dout_q_d[LANES-1] = in_q;
                dout_valid_d      = 1'b1;
                beat_idx_d        = beat_sel_s;
                dout_sof_d        = (beat_sel_s == BEAT_W'(0));
                dout_eof_d        = (beat_sel_s == BEAT_W'(BEATS - 1));
                lane_cnt_d        = LANE_W'(0);
                if (beat_sel_s == BEAT_W'(BEATS - 1)) begin
                    beat_cnt_d = BEAT_W'(0);
                end else begin
                    beat_cnt_d = beat_sel_s + BEAT_W'(1);
                end
            end else begin
                for (int k = 0; k < LANES - 1; k++) begin
                    if (lane_sel_s == LANE_W'(k)) begin
                        stage_i_d[k] = in_i;
                        stage_q_d[k] = in_q;
                    end else begin
                        stage_i_d[k] = stage_i_q[k];
                        stage_q_d[k] = stage_q_q[k];
                    end
                end
                lane_cnt_d = lane_sel_s + LANE_W'(1);
                beat_cnt_d = beat_sel_s;
            end
        end else begin
            lane_cnt_d = lane_cnt_q;
            beat_cnt_d = beat_cnt_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt_q   <= LANE_W'(0);
            beat_cnt_q   <= BEAT_W'(0);
            sync_err_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_eof_q   <= 1'b0;
            beat_idx_q   <= BEAT_W'(0);
            for (int k = 0; k < LANES - 1; k++) begin
                stage_i_q[k] <= IN_WIDTH'(0);
                stage_q_q[k] <= IN_WIDTH'(0);
            end
            for (int k = 0; k < LANES; k++) begin
                dout_i_q[k] <= IN_WIDTH'(0);
                dout_q_q[k] <= IN_WIDTH'(0);
            end
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            sync_err_q   <= sync_err_d;
            dout_valid_q <= dout_valid_d;
            dout_sof_q   <= dout_sof_d;
            dout_eof_q   <= dout_eof_d;
            beat_idx_q   <= beat_idx_d;
            for (int k = 0; k < LANES - 1; k++) begin
                stage_i_q[k] <= stage_i_d[k];
                stage_q_q[k] <= stage_q_d[k];
            end
            for (int k = 0; k < LANES; k++) begin
                dout_i_q[k] <= dout_i_d[k];
                dout_q_q[k] <= dout_q_d[k];
            end
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_sof   = dout_sof_q;
    assign dout_eof   = dout_eof_q;
    assign beat_idx   = beat_idx_q;
    assign dout_i     = dout_i_q;
    assign dout_q     = dout_q_q;
`ifdef FFT_PACKER_FRAME_SYNC_EN
    assign sync_err   = sync_err_q;
`endif

endmodule

// File: tb/tb_fft_input_packer.sv
// Self-checking bench for fft_input_packer: per-cycle comparison against a
// sample-count based reference model, a vector table for extreme values and
// directed sequences for reset, frame wrap and (optionally) frame sync.
module tb_fft_input_packer;

    localparam int W  = 11;
    localparam int L  = 16;
    localparam int FL = 512;
    localparam int NB = FL / L;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic signed [W-1:0] in_i, in_q;
    logic dout_valid, dout_sof, dout_eof;
    logic signed [W-1:0] dout_i [0:L-1];
    logic signed [W-1:0] dout_q [0:L-1];
    logic [4:0] beat_idx;
`ifdef FFT_PACKER_FRAME_SYNC_EN
    logic in_sof;
    logic sync_err;
`endif

    fft_input_packer #(.IN_WIDTH(W), .LANES(L), .FRAME_LEN(FL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_i       (in_i),
        .in_q       (in_q),
`ifdef FFT_PACKER_FRAME_SYNC_EN
        .in_sof     (in_sof),
        .sync_err   (sync_err),
`endif
        .dout_valid (dout_valid),
        .dout_i     (dout_i),
        .dout_q     (dout_q),
        .dout_sof   (dout_sof),
        .dout_eof   (dout_eof),
        .beat_idx   (beat_idx)
    );

    always #5 clk = ~clk;

    // Reference model: samples accepted since reset/resync, pending group, last beat
    int n_acc;
    int pend_i[$];
    int pend_q[$];
    int exp_i [0:L-1];
    int exp_q [0:L-1];
    int exp_valid, exp_beat, exp_err;

    // Counters and sequence statistics
    int n_pass, n_total;
    int cyc, pulse_cnt, first_pulse, last_pulse, min_gap, max_gap;
    int dbl_cnt, sof_cnt, eof_cnt, last_sof_pulse, err_cnt, prev_v;

    typedef struct {
        logic v;
        int   i;
        int   q;
        logic ev;
    } vec_t;
    vec_t tbl [0:20];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic clear_stats();
        cyc = 0; pulse_cnt = 0; first_pulse = -1; last_pulse = 0;
        min_gap = 1000000; max_gap = 0; dbl_cnt = 0; sof_cnt = 0; eof_cnt = 0;
        last_sof_pulse = 0; err_cnt = 0; prev_v = 0;
    endtask

    task automatic model_clear();
        n_acc = 0;
        pend_i.delete();
        pend_q.delete();
        for (int k = 0; k < L; k++) begin
            exp_i[k] = 0;
            exp_q[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b1; in_i = W'(77); in_q = W'(-77);
`ifdef FFT_PACKER_FRAME_SYNC_EN
        in_sof = 1'b1;
`endif
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        model_clear();
        chk("rst_valid", int'(dout_valid), 0);
        chk("rst_sof", int'(dout_sof), 0);
        chk("rst_eof", int'(dout_eof), 0);
        chk("rst_beat_idx", int'(beat_idx), 0);
        begin
            int nz;
            nz = 0;
            for (int k = 0; k < L; k++) if (dout_i[k] != 0 || dout_q[k] != 0) nz++;
            chk("rst_lanes_nonzero", nz, 0);
        end
`ifdef FFT_PACKER_FRAME_SYNC_EN
        chk("rst_sync_err", int'(sync_err), 0);
`endif
    endtask

    task automatic step(input logic v, input int di, input int dq, input logic sof);
        in_valid = v; in_i = W'(di); in_q = W'(dq);
`ifdef FFT_PACKER_FRAME_SYNC_EN
        in_sof = sof;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc++;
        exp_valid = 0;
        exp_err   = 0;
        if (v) begin
`ifdef FFT_PACKER_FRAME_SYNC_EN
            if (sof) begin
                if (n_acc % FL != 0) exp_err = 1;
                n_acc = 0;
                pend_i.delete();
                pend_q.delete();
            end
`endif
            pend_i.push_back(di);
            pend_q.push_back(dq);
            n_acc++;
            if (pend_i.size() == L) begin
                exp_valid = 1;
                exp_beat  = ((n_acc / L) - 1) % NB;
                for (int k = 0; k < L; k++) begin
                    exp_i[k] = pend_i[k];
                    exp_q[k] = pend_q[k];
                end
                pend_i.delete();
                pend_q.delete();
            end
        end
        chk("dout_valid", int'(dout_valid), exp_valid);
        if (exp_valid == 1 && dout_valid) begin
            chk("beat_idx", int'(beat_idx), exp_beat);
            chk("dout_sof", int'(dout_sof), (exp_beat == 0) ? 1 : 0);
            chk("dout_eof", int'(dout_eof), (exp_beat == NB - 1) ? 1 : 0);
            for (int k = 0; k < L; k++) begin
                chk("lane_i", int'(dout_i[k]), exp_i[k]);
                chk("lane_q", int'(dout_q[k]), exp_q[k]);
            end
        end else begin
            int bad;
            bad = 0;
            for (int k = 0; k < L; k++)
                if (int'(dout_i[k]) != exp_i[k] || int'(dout_q[k]) != exp_q[k]) bad++;
            chk("idle_sof", int'(dout_sof), 0);
            chk("idle_eof", int'(dout_eof), 0);
            chk("hold_lanes_changed", bad, 0);
        end
`ifdef FFT_PACKER_FRAME_SYNC_EN
        chk("sync_err", int'(sync_err), exp_err);
        if (sync_err) err_cnt++;
`endif
        if (dout_valid) begin
            if (prev_v != 0) dbl_cnt++;
            pulse_cnt++;
            if (pulse_cnt == 1) first_pulse = cyc;
            else begin
                if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
                if (cyc - last_pulse > max_gap) max_gap = cyc - last_pulse;
            end
            last_pulse = cyc;
            if (dout_sof) begin
                sof_cnt++;
                last_sof_pulse = pulse_cnt;
            end
            if (dout_eof) eof_cnt++;
        end
        prev_v = int'(dout_valid);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b0; in_valid = 1'b0; in_i = '0; in_q = '0;
`ifdef FFT_PACKER_FRAME_SYNC_EN
        in_sof = 1'b0;
`endif
        clear_stats();
        model_clear();

        // 1. One full frame at full rate, ramp data
        do_reset();
        clear_stats();
        for (int n = 0; n < FL; n++) begin
            step(1'b1, n, -n, 1'b0);
            if (dout_valid) begin
                chk("ramp_lane0_i", int'(dout_i[0]), 16 * (pulse_cnt - 1));
                chk("ramp_lane15_q", int'(dout_q[15]), -(16 * (pulse_cnt - 1) + 15));
            end
        end
        step(1'b0, 0, 0, 1'b0);
        chk("frame_pulses", pulse_cnt, 32);
        chk("first_pulse_cycle", first_pulse, 16);
        chk("min_gap", min_gap, 16);
        chk("max_gap", max_gap, 16);
        chk("frame_sof_count", sof_cnt, 1);
        chk("frame_eof_count", eof_cnt, 1);

        // 2. Same data with random gaps
        do_reset();
        clear_stats();
        for (int n = 0; n < FL; n++) begin
            int g;
            g = $urandom_range(0, 2);
            for (int j = 0; j < g; j++) step(1'b0, 0, 0, 1'b0);
            step(1'b1, n, -n, 1'b0);
        end
        step(1'b0, 0, 0, 1'b0);
        chk("gap_pulses", pulse_cnt, 32);
        chk("gap_back_to_back_valid", dbl_cnt, 0);

        // 3. Table-driven extreme values with gaps
        for (int j = 0; j <= 20; j++) begin
            logic gap;
            gap = (j == 2 || j == 5 || j == 9 || j == 13 || j == 20);
            tbl[j].v  = !gap;
            tbl[j].i  = gap ? 0 : -1024;
            tbl[j].q  = gap ? 0 : 1023;
            tbl[j].ev = (j == 19);
        end
        do_reset();
        for (int j = 0; j <= 20; j++) begin
            step(tbl[j].v, tbl[j].i, tbl[j].q, 1'b0);
            chk("tbl_valid", int'(dout_valid), int'(tbl[j].ev));
            if (tbl[j].ev) begin
                for (int k = 0; k < L; k++) begin
                    chk("tbl_lane_i", int'(dout_i[k]), -1024);
                    chk("tbl_lane_q", int'(dout_q[k]), 1023);
                end
            end
        end

        // 4. Reset in the middle of beat 3
        do_reset();
        for (int n = 0; n < 3 * L + 7; n++) step(1'b1, n, -n, 1'b0);
        do_reset();
        clear_stats();
        for (int k = 0; k < L; k++) begin
            step(1'b1, 100 + k, -(100 + k), 1'b0);
            if (dout_valid) begin
                chk("mid_rst_beat_idx", int'(beat_idx), 0);
                chk("mid_rst_sof", int'(dout_sof), 1);
                for (int m = 0; m < L; m++) chk("mid_rst_lane", int'(dout_i[m]), 100 + m);
            end
        end
        chk("mid_rst_pulses", pulse_cnt, 1);

        // 5. Two frames back-to-back
        do_reset();
        clear_stats();
        for (int n = 0; n < 2 * FL; n++) step(1'b1, n % FL, -(n % FL), 1'b0);
        step(1'b0, 0, 0, 1'b0);
        chk("two_frame_pulses", pulse_cnt, 64);
        chk("two_frame_sof", sof_cnt, 2);
        chk("two_frame_eof", eof_cnt, 2);
        chk("second_sof_pulse", last_sof_pulse, 33);
        chk("wrap_min_gap", min_gap, 16);
        chk("wrap_max_gap", max_gap, 16);

        // 6. Random data and random gaps against the model
        do_reset();
        clear_stats();
        for (int n = 0; n < 700; n++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)) - 1024,
                 int'($urandom_range(0, 2047)) - 1024, 1'b0);
        end
        chk("rand_back_to_back_valid", dbl_cnt, 0);

`ifdef FFT_PACKER_FRAME_SYNC_EN
        // 7. Misaligned in_sof at sample 5 of beat 2, then aligned in_sof
        do_reset();
        clear_stats();
        for (int n = 0; n < 2 * L + 5; n++) step(1'b1, n, -n, 1'b0);
        step(1'b1, 500, -500, 1'b1);
        begin
            int post;
            post = 0;
            for (int k = 1; k < L; k++) begin
                step(1'b1, 500 + k, -(500 + k), 1'b0);
                if (dout_valid) begin
                    post++;
                    chk("resync_lane0", int'(dout_i[0]), 500);
                    chk("resync_sof", int'(dout_sof), 1);
                    chk("resync_beat_idx", int'(beat_idx), 0);
                end
            end
            chk("resync_pulses", post, 1);
        end
        step(1'b0, 0, 0, 1'b0);
        chk("sync_err_pulses", err_cnt, 1);
        chk("pre_sync_pulses", pulse_cnt, 3);

        do_reset();
        clear_stats();
        step(1'b1, 1, -1, 1'b1);
        for (int k = 1; k < L; k++) step(1'b1, 1 + k, -(1 + k), 1'b0);
        step(1'b0, 0, 0, 1'b0);
        chk("aligned_sof_err", err_cnt, 0);
        chk("aligned_sof_pulses", pulse_cnt, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_input_packer.md
Name: fft_input_packer

Overview:
- Upstream front end of the FFT pipeline, directly feeding the first butterfly/CBFP stage (module1).
- Accepts one complex sample per valid cycle (serial I/Q, 11-bit signed).
- Packs each 16 consecutive samples into a 16-lane parallel vector and issues a single-cycle valid to module1.
- Tracks position within a 512-point frame and flags the first and last beat of each frame.

Parameters:
- IN_WIDTH, 11, bit width of each signed I and Q sample.
- LANES, 16, samples per output beat (power of 2).
- FRAME_LEN, 512, samples per FFT frame; must be a multiple of LANES. BEATS = FRAME_LEN/LANES (32).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_i/in_q carry a sample this cycle.
- in_i  in  IN_WIDTH signed  real part of the sample.
- in_q  in  IN_WIDTH signed  imaginary part of the sample.
- dout_valid  out  1  one-cycle pulse; the packed vector is valid. Connects to module1 din_valid.
- dout_i  out  IN_WIDTH signed [0:LANES-1]  real lanes.
- dout_q  out  IN_WIDTH signed [0:LANES-1]  imaginary lanes.
- dout_sof  out  1  qualifies dout_valid; first beat of a frame.
- dout_eof  out  1  qualifies dout_valid; last beat of a frame.
- beat_idx  out  $clog2(BEATS)  beat number within the frame for the current dout_valid.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values when rst=1 at a rising edge:
  - dout_valid, dout_sof, dout_eof = 0; beat_idx = 0.
  - All dout_i/dout_q lanes = 0.
  - Lane counter = 0, beat counter = 0, staging registers = 0.
  - rst wins over in_valid in the same cycle.
  - A reset mid-group or mid-frame discards the partial data; the next accepted sample goes to lane 0, beat 0.
- Collection:
  - A sample is accepted on each cycle with in_valid=1. It is written to staging lane[lane_cnt], then lane_cnt increments.
  - Gaps (in_valid=0) are allowed anywhere. Counters hold during gaps and no state changes.
  - Lane k of beat b holds frame sample index b*LANES + k, in arrival order with no reordering.
- Output:
  - When the sample landing in lane LANES-1 is accepted, lanes 0..LANES-2 come from staging and lane LANES-1 comes directly from the input.
  - These are registered into dout_i/dout_q, and dout_valid=1 on the next cycle.
  - Latency: the 16th sample accepted at edge N gives dout_valid high in cycle N+1, for exactly one cycle.
  - dout lanes hold their value until the next beat, so they are stable between pulses.
  - lane_cnt wraps LANES-1 -> 0 with no bubble. Back-to-back full-rate input gives dout_valid every 16 cycles.
- Frame tracking:
  - beat_cnt increments on each emitted beat and wraps BEATS-1 -> 0.
  - dout_sof=1 when the emitted beat_idx==0; dout_eof=1 when beat_idx==BEATS-1.
  - Both flags are 0 whenever dout_valid=0.
- No backpressure: module1 always accepts, and there is no ready signal.
- Arithmetic: none. Samples pass bit-exact, with sign preserved.

Optional Feature:
- Macro FFT_PACKER_FRAME_SYNC_EN.
- When defined, the block adds input port in_sof (1 bit, qualified by in_valid) and output port sync_err (1 bit, one-cycle pulse).
  - in_sof=1 with in_valid=1 forces that sample into lane 0 of beat 0.
  - If lane_cnt!=0 or beat_cnt!=0 at that moment, the partial group/frame is dropped, no dout_valid is issued for it, and sync_err pulses the next cycle.
  - An in_sof that arrives exactly on an aligned boundary (lane 0, beat 0) gives no error.
  - sync_err resets to 0.
- When not defined, neither port exists and the counters free-run from reset.

Test Plan:
- Reset then 512 consecutive valid samples with in_i=n, in_q=-n (n=0..511):
  - 32 dout_valid pulses, 16 cycles apart, the first one cycle after sample 15.
  - Beat b has dout_i[k]=16b+k and dout_q[k]=-(16b+k).
  - sof only on beat 0, eof only on beat 31.
- Random in_valid gaps (about 50% duty) with the same data: identical beat contents; dout_valid never high for 2 consecutive cycles; outputs hold between pulses.
- Extreme values in_i=-1024, in_q=1023 on all 16 samples: every lane reads back exactly -1024/1023.
- Assert rst after 7 samples of beat 3, then feed 16 samples of value 100+k: one beat with lane k=100+k, beat_idx=0, dout_sof=1, and no stale data.
- Run two full frames back-to-back: beat_idx wraps 31->0, sof asserts on beat 32 overall, and there is no bubble at the wrap.
- With FFT_PACKER_FRAME_SYNC_EN, assert in_sof on sample 5 of beat 2:
  - sync_err pulses once.
  - The next dout_valid carries samples starting at the sof sample in lane 0, with dout_sof=1.
  - An aligned in_sof (lane 0, beat 0) gives no sync_err.
